// File: rtl/program_loader_pkg.sv
// Shared loader/processor definitions: default memory geometry and the
// 2-bit loader FSM state encoding.
package program_loader_pkg;

  localparam int PL_ADDR_W = 4;
  localparam int PL_DATA_W = 16;
  localparam int PL_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DONE = 2'd3
  } ld_state_e;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian byte pairs into instruction
// words and writes them to an external instruction memory while holding the CPU.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = PL_ADDR_W,
  parameter int DATA_W = PL_DATA_W,
  parameter int BYTE_W = PL_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(1 << ADDR_W);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]   lim_q, lim_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic hs, legal, last;

  assign in_ready = (state_q == ST_HI) || (state_q == ST_LO);
  assign hs       = in_valid && in_ready;
  assign legal    = (num_words != '0) && (num_words <= MAX_WORDS);
  // Compare one bit wider so a 16-word load terminates at address 15.
  assign last     = ({1'b0, cnt_q} == (lim_q - 1'b1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (legal) begin
            state_d = ST_HI;
            lim_d   = num_words;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HI: begin
        if (hs) begin
          hi_d    = in_data;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (hs) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = {hi_q, in_data};
          if (last) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_HI;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // DONE is also the cycle of the final write, so hold spans it.
  assign busy      = (state_q != ST_IDLE);
  assign cpu_hold  = busy;
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, instruction-memory address width (16 entries).
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 SHALL have parameter BYTE_W, default 8, input stream width; DATA_W = 2*BYTE_W.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port num_words  input  ADDR_W+1  word count for the load, sampled with start; legal range 1..16.
REQ-008 SHALL have port in_valid  input  1  stream byte valid.
REQ-009 SHALL have port in_data  input  BYTE_W  stream byte, high byte of each word first.
REQ-010 SHALL have port in_ready  output  1  loader accepts byte when in_valid && in_ready.
REQ-011 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-012 SHALL have port mem_waddr  output  ADDR_W  write address.
REQ-013 SHALL have port mem_wdata  output  DATA_W  write data {high byte, low byte}.
REQ-014 SHALL have port cpu_hold  output  1  holds processor pc/pipeline while loading.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-017 SHALL have port error  output  1  one-cycle pulse when start carries illegal num_words.

Function
REQ-018 SHALL implement FSM states IDLE, HI, LO, DONE.
REQ-019 IDLE: start && num_words in 1..16 -> HI; latch num_words; word counter := 0.
REQ-020 IDLE: start && (num_words == 0 || num_words > 16) -> stay IDLE; error = 1 next cycle for exactly one cycle.
REQ-021 in_ready SHALL be 1 only in HI and LO; 0 in IDLE and DONE.
REQ-022 HI: on handshake, latch in_data as high byte -> LO; no handshake -> stay HI (in_valid gaps of any length tolerated).
REQ-023 LO: on handshake, register mem_we=1, mem_waddr=counter, mem_wdata={high, in_data} for the following cycle only (latency 1 cycle after low-byte handshake).
REQ-024 LO handshake: if counter == latched_count-1 -> DONE, else counter+1 and -> HI.
REQ-025 DONE: done = 1 for one cycle, -> IDLE.
REQ-026 cpu_hold SHALL be 1 from the cycle after accepted start through the DONE cycle inclusive, covering the final mem_we cycle.
REQ-027 start while busy SHALL be ignored (no error, no restart).
REQ-028 Counter SHALL be ADDR_W bits; num_words = 16 writes addresses 0..15 with no wrap beyond 15.
REQ-029 mem_we SHALL never assert outside a load; mem_waddr/mem_wdata hold last value when mem_we = 0.

Reset
REQ-030 rst SHALL force state IDLE, counter 0, in_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, cpu_hold 0, busy 0, done 0, error 0.
REQ-031 rst mid-load SHALL discard any partial word (high byte pending); already-written memory words are not erased.
REQ-032 rst asserted together with start SHALL win; no load begins.

Structure
REQ-033 ADDR_W, DATA_W, BYTE_W defaults and the FSM state encoding (2 bits) SHALL live in a shared package used by the processor and loader.
REQ-034 Loader SHALL be a single module without sub-modules; the instruction memory write port is external and driven by mem_we/mem_waddr/mem_wdata.

Verification
REQ-035 start, num_words=3; bytes 11,23,22,34,33,08 back-to-back -> writes 0x1123@0, 0x2234@1, 0x3308@2, each 1 cycle after its low byte; done 1 cycle after last write; cpu_hold low afterward.
REQ-036 num_words=16, in_valid toggled every other cycle -> 16 writes to 0..15, no write to wrap address, single done pulse.
REQ-037 start with num_words=0, then 17 -> error pulse each, busy stays 0, no mem_we, in_ready 0.
REQ-038 num_words=2, rst after first high byte 0xAB -> all outputs zero next cycle; a new load with bytes 12,34 writes 0x1234@0 (0xAB not used).
REQ-039 start pulsed during HI of a 2-word load -> ignored; exactly 2 writes, one done.
REQ-040 in_valid=1 in IDLE and DONE -> in_ready=0, no byte consumed, no mem_we.
